unified_buffer_mp: RTL
======================

# unified_buffer_mp

Parametrised multi-lane unified buffer: `NUM_LANES`-wide compacting write port and a burst read engine with optional per-lane staggered (systolic skew) output. It sits between the activation/Leaky-ReLU output path (writes) and the input/weight accumulators feeding the systolic array (reads). Writes and reads run concurrently. Memory is flop-based and cleared on reset.

## Interface
Parameters:
- `DATA_WIDTH`, 16: element width (fixed-point word).
- `DEPTH`, 64: number of elements; must be a power of two, at least `2*NUM_LANES`.
- `NUM_LANES`, 2: elements per write/read beat, 1..8.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: derived; do not override.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `ub_wr_start_in`  in  1  load the write pointer from `ub_wr_addr_in`.
- `ub_wr_addr_in`  in  ADDR_WIDTH  write base address.
- `ub_wr_data_in`  in  NUM_LANES×DATA_WIDTH  write data, lane 0 in the LSBs.
- `ub_wr_valid_in`  in  NUM_LANES  per-lane write valid.
- `ub_wr_ptr_out`  out  ADDR_WIDTH  current write pointer.
- `ub_rd_start_in`  in  1  request a burst read.
- `ub_rd_addr_in`  in  ADDR_WIDTH  read base address.
- `ub_rd_count_in`  in  ADDR_WIDTH+1  number of elements to read, 0..DEPTH.
- `ub_rd_stagger_in`  in  1  1 delays lane i by i cycles.
- `ub_rd_data_out`  out  NUM_LANES×DATA_WIDTH  read data.
- `ub_rd_valid_out`  out  NUM_LANES  per-lane read valid.
- `ub_rd_busy_out`  out  1  read engine occupied.
- `ub_rd_done_out`  out  1  one-cycle pulse at burst completion.

## Operation
- Reset: all memory, the write pointer, the data and valid outputs, busy and done are 0. The FSM returns to IDLE. Reset asserted mid-burst aborts the burst with no done pulse.
- Write pointer load:
  - `ub_wr_start_in` sets the pointer to `ub_wr_addr_in`.
  - Valid lanes in the same cycle write starting at `ub_wr_addr_in`.
- Compacting write:
  - Valid lanes are written in ascending lane order to consecutive addresses `ptr, ptr+1, …`, skipping invalid lanes.
  - The pointer advances by popcount(`ub_wr_valid_in`).
  - All address arithmetic is mod DEPTH: writes wrap, and there is no overflow flag.
- Read FSM states: IDLE, READ, DRAIN.
  - IDLE: `ub_rd_start_in` is accepted. The engine latches addr, count and stagger, and sets remaining = count, B = ceil(count/NUM_LANES).
    - count = 0: no valids, busy stays 0, done pulses the next cycle.
    - Otherwise: go to READ.
  - READ, each cycle:
    - Lane i (i < min(NUM_LANES, remaining)) is loaded with mem[(rd_ptr+i) mod DEPTH] and valid = 1; other lanes get valid = 0.
    - rd_ptr += NUM_LANES; remaining −= min(NUM_LANES, remaining).
    - When remaining reaches 0: go to DRAIN if stagger and NUM_LANES > 1, else go to IDLE.
  - DRAIN: stay NUM_LANES−1 cycles flushing the skew registers, then go to IDLE.
- `ub_rd_start_in` while busy is ignored and not queued.
- A read and a write to the same address in the same cycle: the read returns the old data (read-before-write).
- Write activity never stalls the read engine.

## Timing
- Start is sampled at edge E0. Beat j (0..B−1) is registered at edge E0+1+j, so data is valid in cycle E0+1+j (1-cycle latency).
- Stagger: lane i of beat j is valid in cycle E0+1+j+i; zero-skew lanes are unchanged.
- `ub_rd_done_out` is high for exactly one cycle, coincident with the last valid beat:
  - cycle E0+B without stagger;
  - cycle E0+B+NUM_LANES−1 with stagger.
- `ub_rd_busy_out` is high from cycle E0+1 through the done cycle inclusive. A new start is accepted in the done cycle's following edge, so bursts can be back-to-back with no gap cycle.
- `ub_wr_ptr_out` reflects the update one cycle after the write edge.

## Structure
- Package `ub_pkg` holds:
  - default `DATA_WIDTH`;
  - typedef `ub_data_t` (logic [DATA_WIDTH-1:0]);
  - enum `ub_rd_state_e` {IDLE, READ, DRAIN};
  - a `popcount` function.
- Sub-module `ub_lane_skew`: per-lane delay line of depth LANE_IDX (0 = wire), instantiated NUM_LANES times via generate. It carries data and valid, has a bypass controlled by the latched stagger bit, and clears on `rst`.

## Test plan
- Reset then read addr 0 count 4, NUM_LANES=2:
  - cycles E0+1 and E0+2 give data 0, valids 2'b11;
  - busy is high in cycles E0+1..E0+2;
  - done is high in cycle E0+2.
- Write base 10, four beats of {A,B} with valids 2'b11, 2'b01, 2'b10, 2'b11 → mem[10..15] = A0,B0,A1,B2,A3,B3, and `ub_wr_ptr_out` = 16.
- Write base 62 with 2'b11 twice (DEPTH=64) → mem[62], mem[63], mem[0], mem[1] are written and the pointer = 2. A read from addr 63 with count 3 returns mem[63], mem[0], mem[1] with valids 2'b11 then 2'b01.
- Stagger read addr 0 count 6, NUM_LANES=2:
  - lane 0 valid in cycles E0+1..E0+3;
  - lane 1 valid in cycles E0+2..E0+4;
  - done in cycle E0+4;
  - a second start in cycle E0+2 is ignored.
- Read count 0 → no valids, done one cycle at E0+1. Separately, a read of addr 5 while writing addr 5 in the same cycle returns the old value.
- Assert `rst` in cycle E0+2 of an 8-element burst → valids, busy and done are 0 the next cycle, there is no done pulse, and memory reads back 0.

Source files
------------

// File: rtl/ub_pkg.sv
// ============================================================================
// Module  : ub_pkg
// Purpose : Shared types, read-engine states and helpers for the unified buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ub_pkg;

    localparam int UB_DEFAULT_DATA_WIDTH = 16;
    localparam int UB_MAX_LANES          = 8;

    typedef logic [UB_DEFAULT_DATA_WIDTH-1:0] ub_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } ub_rd_state_e;

    function automatic logic [3:0] popcount(input logic [UB_MAX_LANES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < UB_MAX_LANES; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ub_lane_skew.sv
// ============================================================================
// Module  : ub_lane_skew
// Purpose : Per-lane delay line of LANE_IDX cycles with bypass (systolic skew).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ub_lane_skew #(
    parameter int DATA_WIDTH = 16,
    parameter int LANE_IDX   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_bypass,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    generate
        if (LANE_IDX == 0) begin : g_wire
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, i_bypass};
            assign o_data   = i_data;
            assign o_valid  = i_valid;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] r_data  [LANE_IDX];
            logic                  r_valid [LANE_IDX];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < LANE_IDX; k++) begin
                        r_data[k]  <= '0;
                        r_valid[k] <= 1'b0;
                    end
                end else begin
                    r_data[0]  <= i_data;
                    r_valid[0] <= i_valid;
                    for (int k = 1; k < LANE_IDX; k++) begin
                        r_data[k]  <= r_data[k-1];
                        r_valid[k] <= r_valid[k-1];
                    end
                end
            end

            assign o_data  = i_bypass ? i_data  : r_data[LANE_IDX-1];
            assign o_valid = i_bypass ? i_valid : r_valid[LANE_IDX-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/unified_buffer_mp.sv
// ============================================================================
// Module  : unified_buffer_mp
// Purpose : Multi-lane unified buffer: compacting write port, burst read engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module unified_buffer_mp
    import ub_pkg::*;
#(
    parameter int DATA_WIDTH = UB_DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 64,
    parameter int NUM_LANES  = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ub_wr_start_in,
    input  logic [ADDR_WIDTH-1:0]           ub_wr_addr_in,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] ub_wr_data_in,
    input  logic [NUM_LANES-1:0]            ub_wr_valid_in,
    output logic [ADDR_WIDTH-1:0]           ub_wr_ptr_out,
    input  logic                            ub_rd_start_in,
    input  logic [ADDR_WIDTH-1:0]           ub_rd_addr_in,
    input  logic [ADDR_WIDTH:0]             ub_rd_count_in,
    input  logic                            ub_rd_stagger_in,
    output logic [NUM_LANES*DATA_WIDTH-1:0] ub_rd_data_out,
    output logic [NUM_LANES-1:0]            ub_rd_valid_out,
    output logic                            ub_rd_busy_out,
    output logic                            ub_rd_done_out
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] w_wr_base;
    logic [ADDR_WIDTH-1:0] w_wr_addr [NUM_LANES];
    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic [3:0]            w_wr_cnt;

    // Each valid lane lands at base + number of valid lanes below it.
    always_comb begin
        w_wr_base = ub_wr_start_in ? ub_wr_addr_in : r_wr_ptr;
        w_wr_cnt  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_wr_addr[i] = w_wr_base + ADDR_WIDTH'(w_wr_cnt);
            w_wr_cnt     = w_wr_cnt + {3'b000, ub_wr_valid_in[i]};
        end
        w_wr_ptr_nxt = w_wr_base + ADDR_WIDTH'(popcount(UB_MAX_LANES'(ub_wr_valid_in)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (ub_wr_valid_in[i]) begin
                    r_mem[w_wr_addr[i]] <= ub_wr_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    ub_rd_state_e                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]         r_rd_ptr, w_rd_ptr;
    logic [CW-1:0]                 r_rem, w_rem, w_take, w_rem_nxt;
    logic                          r_stagger, w_stagger;
    logic [3:0]                    r_drain_cnt;
    logic                          w_accept, w_beat, w_last_beat, w_use_drain;
    logic                          w_drain_done, w_done_nxt;
    logic [NUM_LANES*DATA_WIDTH-1:0] w_rd_data, r_beat_data;
    logic [NUM_LANES-1:0]          w_lane_valid, r_beat_valid;
    logic                          r_busy, r_done;

    // The accepting edge already registers the first beat, giving 1-cycle latency.
    always_comb begin
        w_accept     = (r_state == IDLE) & ub_rd_start_in;
        w_rd_ptr     = (r_state == IDLE) ? ub_rd_addr_in    : r_rd_ptr;
        w_rem        = (r_state == IDLE) ? ub_rd_count_in   : r_rem;
        w_stagger    = (r_state == IDLE) ? ub_rd_stagger_in : r_stagger;
        w_beat       = (r_state == READ) | (w_accept & (ub_rd_count_in != '0));
        w_take       = (w_rem < CW'(NUM_LANES)) ? w_rem : CW'(NUM_LANES);
        w_rem_nxt    = w_rem - w_take;
        w_last_beat  = w_beat & (w_rem_nxt == '0);
        w_use_drain  = w_stagger & (NUM_LANES > 1);
        w_drain_done = (r_state == DRAIN) & (r_drain_cnt == '0);
        w_done_nxt   = (w_accept & (ub_rd_count_in == '0))
                     | (w_last_beat & ~w_use_drain) | w_drain_done;
        w_rd_data    = '0;
        w_lane_valid = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_rd_ptr + ADDR_WIDTH'(i)];
            w_lane_valid[i] = (CW'(i) < w_rem);
        end

        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_beat) w_state_nxt = w_last_beat ? (w_use_drain ? DRAIN : IDLE) : READ;
            READ:    if (w_last_beat) w_state_nxt = w_use_drain ? DRAIN : IDLE;
            DRAIN:   if (w_drain_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_rem        <= '0;
            r_stagger    <= 1'b0;
            r_drain_cnt  <= '0;
            r_beat_data  <= '0;
            r_beat_valid <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (w_accept) r_stagger <= ub_rd_stagger_in;
            if (w_beat) begin
                r_rd_ptr    <= w_rd_ptr + ADDR_WIDTH'(NUM_LANES);
                r_rem       <= w_rem_nxt;
                r_beat_data <= w_rd_data;
            end
            r_drain_cnt  <= (r_state == DRAIN) ? r_drain_cnt - 4'd1 : 4'(NUM_LANES - 2);
            r_beat_valid <= w_beat ? w_lane_valid : '0;
            r_busy       <= w_beat | (r_state == DRAIN);
            r_done       <= w_done_nxt;
        end
    end

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            ub_lane_skew #(
                .DATA_WIDTH (DATA_WIDTH),
                .LANE_IDX   (g)
            ) u_skew (
                .clk      (clk),
                .rst      (rst),
                .i_bypass (~r_stagger),
                .i_data   (r_beat_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .i_valid  (r_beat_valid[g]),
                .o_data   (ub_rd_data_out[g*DATA_WIDTH +: DATA_WIDTH]),
                .o_valid  (ub_rd_valid_out[g])
            );
        end
    endgenerate

    assign ub_wr_ptr_out  = r_wr_ptr;
    assign ub_rd_busy_out = r_busy;
    assign ub_rd_done_out = r_done;

endmodule

`default_nettype wire
